// File: rtl/cache_request_controller.sv
// Requester half of a snooping MSI cache controller: serves CPU hits locally and
// drives read-miss / write-miss / invalidate / writeback transactions on the shared bus.
module cache_request_controller #(
  parameter int INDEX_BITS = 2,
  parameter int TAG_BITS   = 4,
  parameter int DATA_W     = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cpu_valid,
  input  logic                           cpu_write,
  input  logic [TAG_BITS+INDEX_BITS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]              cpu_wdata,
  output logic                           cpu_ready,
  output logic                           cpu_done,
  output logic                           cpu_hit,
  output logic [DATA_W-1:0]              cpu_rdata,
  output logic                           bus_req,
  input  logic                           bus_grant,
  output logic [2:0]                     bus_cmd,
  output logic [TAG_BITS+INDEX_BITS-1:0] bus_addr,
  output logic [DATA_W-1:0]              bus_wdata,
  input  logic                           bus_done,
  input  logic [DATA_W-1:0]              bus_rdata,
  input  logic                           snoop_valid,
  input  logic [INDEX_BITS-1:0]          snoop_index,
  input  logic [1:0]                     snoop_state,
  output logic [DATA_W-1:0]              snoop_rdata
);

  localparam int ADDR_W = TAG_BITS + INDEX_BITS;
  localparam int LINES  = 1 << INDEX_BITS;

  localparam logic [1:0] LS_INV = 2'b00;
  localparam logic [1:0] LS_SHR = 2'b01;
  localparam logic [1:0] LS_EXC = 2'b10;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_RDM  = 3'b001;
  localparam logic [2:0] CMD_WRM  = 3'b010;
  localparam logic [2:0] CMD_INV  = 3'b011;
  localparam logic [2:0] CMD_WB   = 3'b100;

  typedef enum logic [2:0] {
    IDLE, CHECK, WB_ARB, WB_XFER, MISS_ARB, MISS_XFER, RESP
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  logic [1:0]          line_state [LINES];
  logic [TAG_BITS-1:0] line_tag   [LINES];
  logic [DATA_W-1:0]   line_data  [LINES];

  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [2:0]          cmd_q;
  logic                hit_q;
  logic [DATA_W-1:0]   resp_data;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [1:0]            cur_state;
  logic [TAG_BITS-1:0]   cur_tag;
  logic [DATA_W-1:0]     cur_data;
  logic                  line_hit;
  logic                  upgrade_lost;

  assign req_index = req_addr[INDEX_BITS-1:0];
  assign req_tag   = req_addr[ADDR_W-1:INDEX_BITS];
  assign cur_state = line_state[req_index];
  assign cur_tag   = line_tag[req_index];
  assign cur_data  = line_data[req_index];
  assign line_hit  = (cur_state != LS_INV) && (cur_tag == req_tag);

  // A pending upgrade turns into a write miss once our copy is gone, including
  // an invalidation landing on this very edge.
  assign upgrade_lost = (cur_state == LS_INV) ||
                        (snoop_valid && snoop_index == req_index && snoop_state == LS_INV);

  assign snoop_rdata = line_data[snoop_index];

  always_ff @(posedge clock) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:      if (cpu_valid) fsm_d = CHECK;
      CHECK: begin
        if (line_hit && (!req_write || cur_state == LS_EXC)) fsm_d = RESP;
        else if (line_hit)                                   fsm_d = MISS_ARB;
        else if (cur_state == LS_EXC)                        fsm_d = WB_ARB;
        else                                                 fsm_d = MISS_ARB;
      end
      WB_ARB:    if (bus_grant) fsm_d = WB_XFER;
      WB_XFER:   if (bus_done)  fsm_d = MISS_ARB;
      MISS_ARB:  if (bus_grant) fsm_d = MISS_XFER;
      MISS_XFER: if (bus_done)  fsm_d = RESP;
      RESP:      fsm_d = IDLE;
      default:   fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the line arrays are reset explicitly; coherence depends on every line starting invalid.
      for (int i = 0; i < LINES; i++) begin
        line_state[i] <= LS_INV;
        line_tag[i]   <= '0;
        line_data[i]  <= '0;
      end
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      cmd_q     <= CMD_IDLE;
      hit_q     <= 1'b0;
      resp_data <= '0;
    end else begin
      // NOTE: non-blocking writes to the same element resolve to the last one, so the
      // controller updates below override a same-edge snoop update.
      if (snoop_valid) line_state[snoop_index] <= snoop_state;
      case (fsm_q)
        IDLE: if (cpu_valid) begin
          req_write <= cpu_write;
          req_addr  <= cpu_addr;
          req_wdata <= cpu_wdata;
        end
        CHECK: begin
          if (line_hit && !req_write) begin
            hit_q     <= 1'b1;
            resp_data <= cur_data;
          end else if (line_hit && cur_state == LS_EXC) begin
            hit_q                <= 1'b1;
            resp_data            <= req_wdata;
            line_data[req_index] <= req_wdata;
          end else begin
            hit_q <= 1'b0;
            cmd_q <= line_hit ? CMD_INV : (req_write ? CMD_WRM : CMD_RDM);
          end
        end
        WB_XFER: if (bus_done) line_state[req_index] <= LS_INV;
        MISS_ARB: if (cmd_q == CMD_INV && upgrade_lost) cmd_q <= CMD_WRM;
        MISS_XFER: if (bus_done) begin
          case (cmd_q)
            CMD_RDM: begin
              line_tag[req_index]   <= req_tag;
              line_data[req_index]  <= bus_rdata;
              line_state[req_index] <= LS_SHR;
              resp_data             <= bus_rdata;
            end
            CMD_WRM: begin
              line_tag[req_index]   <= req_tag;
              line_data[req_index]  <= req_wdata;
              line_state[req_index] <= LS_EXC;
              resp_data             <= req_wdata;
            end
            default: begin
              line_data[req_index]  <= req_wdata;
              line_state[req_index] <= LS_EXC;
              resp_data             <= req_wdata;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_ready = 1'b0;
    cpu_done  = 1'b0;
    cpu_hit   = 1'b0;
    cpu_rdata = '0;
    bus_req   = 1'b0;
    bus_cmd   = CMD_IDLE;
    bus_addr  = '0;
    bus_wdata = '0;
    case (fsm_q)
      IDLE:     cpu_ready = 1'b1;
      WB_ARB:   bus_req   = 1'b1;
      WB_XFER: begin
        bus_req   = 1'b1;
        bus_cmd   = CMD_WB;
        bus_addr  = {cur_tag, req_index};
        bus_wdata = cur_data;
      end
      MISS_ARB: bus_req   = 1'b1;
      MISS_XFER: begin
        bus_req  = 1'b1;
        bus_cmd  = cmd_q;
        bus_addr = req_addr;
      end
      RESP: begin
        cpu_done  = 1'b1;
        cpu_hit   = hit_q;
        cpu_rdata = resp_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_request_controller.sv
// Directed scoreboard bench for cache_request_controller: stimulus pushes expected
// CPU responses and bus transfers; a negedge monitor pops and compares them.
module tb_cache_request_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_valid = 1'b0;
  logic       cpu_write = 1'b0;
  logic [5:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_ready, cpu_done, cpu_hit;
  logic [7:0] cpu_rdata;
  logic       bus_req;
  logic       bus_grant = 1'b0;
  logic [2:0] bus_cmd;
  logic [5:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_done = 1'b0;
  logic [7:0] bus_rdata = '0;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_index = '0;
  logic [1:0] snoop_state = '0;
  logic [7:0] snoop_rdata;

  cache_request_controller #(.INDEX_BITS(2), .TAG_BITS(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_done(bus_done), .bus_rdata(bus_rdata),
    .snoop_valid(snoop_valid), .snoop_index(snoop_index), .snoop_state(snoop_state),
    .snoop_rdata(snoop_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       hit;
    logic [7:0] rdata;
    int         lat;    // accept-to-done cycles, 0 = not checked
  } resp_t;

  typedef struct {
    logic [2:0] cmd;
    logic [5:0] addr;
    logic [7:0] wdata;  // compared for writebacks only
  } bus_t;

  resp_t exp_resp[$];
  bus_t  exp_bus[$];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int grant_delay = 0;
  int req_cycles = 0;
  bit hold_done = 1'b0;
  logic [7:0] fill_data = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus agent: grants after grant_delay request cycles, completes each transfer in one cycle.
  initial forever begin
    @(negedge clock);
    if (bus_req) begin
      if (req_cycles >= grant_delay) bus_grant = 1'b1;
      req_cycles++;
    end else begin
      req_cycles = 0;
      bus_grant  = 1'b0;
    end
    bus_rdata = fill_data;
    bus_done  = (bus_cmd != 3'b000) && !bus_done && !hold_done;
  end

  // Monitor / scoreboard.
  initial begin
    logic [2:0] prev_cmd;
    logic       prev_req;
    resp_t      r;
    bus_t       b;
    prev_cmd = '0;
    prev_req = 1'b0;
    forever begin
      @(negedge clock);
      if (cpu_done) begin
        if (exp_resp.size() == 0) check("cpu_done_unexpected", 1, 0);
        else begin
          r = exp_resp.pop_front();
          check("cpu_hit", cpu_hit, r.hit);
          check("cpu_rdata", cpu_rdata, r.rdata);
          if (r.lat > 0) check("hit_latency", cyc - accept_cyc + 1, r.lat);
        end
      end
      if (bus_cmd != 3'b000 && prev_cmd == 3'b000) begin
        if (exp_bus.size() == 0) check("bus_xfer_unexpected", {29'd0, bus_cmd}, 0);
        else begin
          b = exp_bus.pop_front();
          check("bus_cmd", bus_cmd, b.cmd);
          check("bus_addr", bus_addr, b.addr);
          if (b.cmd == 3'b100) check("bus_wdata", bus_wdata, b.wdata);
        end
      end
      if (bus_req && !prev_req && exp_bus.size() == 0) check("bus_req_unexpected", 1, 0);
      if (!bus_req && prev_req && exp_bus.size() != 0) check("bus_req_gap", 0, 1);
      prev_cmd = bus_cmd;
      prev_req = bus_req;
    end
  end

  task automatic do_req(input logic w, input logic [5:0] addr, input logic [7:0] wdata);
    int n = 0;
    @(negedge clock);
    while (!cpu_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!cpu_ready) check("ready_timeout", 0, 1);
    cpu_valid  = 1'b1;
    cpu_write  = w;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    accept_cyc = cyc;
    @(negedge clock);
    cpu_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_resp.size() != 0 || bus_req) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      check("idle_timeout", 0, 1);
      exp_resp.delete();
      exp_bus.delete();
    end
  endtask

  task automatic snoop(input logic [1:0] idx, input logic [1:0] st);
    @(negedge clock);
    snoop_valid = 1'b1;
    snoop_index = idx;
    snoop_state = st;
    @(negedge clock);
    snoop_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_cpu_ready", cpu_ready, 1);
    check("reset_bus_req", bus_req, 0);
    check("reset_bus_cmd", bus_cmd, 0);
    check("reset_cpu_done", cpu_done, 0);
    check("reset_line_data", snoop_rdata, 8'h00);

    // Cold read miss, grant two cycles after request.
    grant_delay = 2;
    fill_data   = 8'hA5;
    exp_bus.push_back('{3'b001, 6'h12, 8'h00});
    exp_resp.push_back('{1'b0, 8'hA5, 0});
    do_req(1'b0, 6'h12, 8'h00);
    wait_idle();

    // Re-read hits in three cycles with no bus activity.
    grant_delay = 0;
    exp_resp.push_back('{1'b1, 8'hA5, 3});
    do_req(1'b0, 6'h12, 8'h00);
    wait_idle();

    // Write to a shared line upgrades with an invalidate.
    exp_bus.push_back('{3'b011, 6'h12, 8'h00});
    exp_resp.push_back('{1'b0, 8'h3C, 0});
    do_req(1'b1, 6'h12, 8'h3C);
    wait_idle();
    exp_resp.push_back('{1'b1, 8'h3C, 3});
    do_req(1'b0, 6'h12, 8'h00);
    wait_idle();
    exp_resp.push_back('{1'b1, 8'h3C, 3});
    do_req(1'b1, 6'h12, 8'h3C);
    wait_idle();

    // Conflicting write evicts the dirty line before the write miss.
    exp_bus.push_back('{3'b100, 6'h12, 8'h3C});
    exp_bus.push_back('{3'b010, 6'h32, 8'h00});
    exp_resp.push_back('{1'b0, 8'h77, 0});
    do_req(1'b1, 6'h32, 8'h77);
    wait_idle();
    exp_resp.push_back('{1'b1, 8'h77, 3});
    do_req(1'b0, 6'h32, 8'h00);
    wait_idle();
    exp_resp.push_back('{1'b1, 8'h55, 3});
    do_req(1'b1, 6'h32, 8'h55);
    wait_idle();
    snoop_index = 2'd2;
    #1 check("line2_after_write_hit", snoop_rdata, 8'h55);

    // Snoop downgrade: data visible to the snooper, next write must upgrade.
    @(negedge clock);
    snoop_valid = 1'b1;
    snoop_index = 2'd2;
    snoop_state = 2'b01;
    #1 check("snoop_rdata", snoop_rdata, 8'h55);
    @(negedge clock);
    snoop_valid = 1'b0;
    exp_bus.push_back('{3'b011, 6'h32, 8'h00});
    exp_resp.push_back('{1'b0, 8'h66, 0});
    do_req(1'b1, 6'h32, 8'h66);
    wait_idle();

    // Invalidate arrives while the upgrade waits for grant: write miss is issued instead.
    snoop(2'd2, 2'b01);
    grant_delay = 6;
    exp_bus.push_back('{3'b010, 6'h32, 8'h00});
    exp_resp.push_back('{1'b0, 8'h99, 0});
    do_req(1'b1, 6'h32, 8'h99);
    snoop(2'd2, 2'b00);
    wait_idle();
    snoop_index = 2'd2;
    #1 check("line2_after_upgrade_lost", snoop_rdata, 8'h99);

    // Reset during a bus transfer drops the request without completion.
    grant_delay = 0;
    hold_done   = 1'b1;
    exp_bus.push_back('{3'b001, 6'h05, 8'h00});
    do_req(1'b0, 6'h05, 8'h00);
    n = 0;
    while (bus_cmd == 3'b000 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("xfer_reached", {29'd0, bus_cmd}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    hold_done = 1'b0;
    check("midreset_bus_req", bus_req, 0);
    check("midreset_bus_cmd", bus_cmd, 0);
    check("midreset_cpu_ready", cpu_ready, 1);
    check("midreset_cpu_done", cpu_done, 0);
    snoop_index = 2'd2;
    #1 check("midreset_line_data", snoop_rdata, 8'h00);

    // Previously dirty line is now invalid: plain read miss, no writeback.
    fill_data = 8'h44;
    exp_bus.push_back('{3'b001, 6'h32, 8'h00});
    exp_resp.push_back('{1'b0, 8'h44, 0});
    do_req(1'b0, 6'h32, 8'h00);
    wait_idle();
    repeat (4) @(negedge clock);
    check("resp_queue_empty", exp_resp.size(), 0);
    check("bus_queue_empty", exp_bus.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
